// File: rtl/cordic_request_arbiter_pkg.sv
// Shared CORDIC definitions: operating modes, fixed-point widths and core latency.
// Used by the request arbiter and by blocks that drive the CORDIC core.
package cordic_pkg;

    localparam int CORDIC_INT_BITS    = 3;
    localparam int CORDIC_FRAC_BITS   = 30;
    localparam int CORDIC_BITS        = CORDIC_INT_BITS + CORDIC_FRAC_BITS;
    localparam int CORDIC_N_ITERATION = 12;
    // One extra stage for the core's input register.
    localparam int CORDIC_LATENCY     = CORDIC_N_ITERATION + 1;

    typedef enum logic [1:0] {
        LINEAR     = 2'b00,
        CIRCULAR   = 2'b01,
        HYPERBOLIC = 2'b11
    } cordic_mode_e;

    function automatic logic signed [CORDIC_BITS-1:0] to_fixed(input int signed whole);
        logic signed [CORDIC_BITS-1:0] v;
        v = CORDIC_BITS'(whole);
        return v <<< CORDIC_FRAC_BITS;
    endfunction

endpackage

// File: rtl/cordic_request_arbiter_rr_arbiter.sv
// Round-robin arbiter: grants the first active request at or after the pointer,
// wrapping, and returns the grant both one-hot and encoded.
module rr_arbiter
    import cordic_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [ID_W-1:0]  i_ptr,
    input  logic             i_en,
    output logic [N_REQ-1:0] o_grant,
    output logic [ID_W-1:0]  o_id,
    output logic             o_valid
);

    logic [N_REQ-1:0][ID_W-1:0] w_idx;
    logic [N_REQ-1:0]           w_rot_req;

    // Rotate the request vector so that position 0 is the pointer's requester.
    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_rot
            logic [ID_W:0] w_sum;
            assign w_sum          = {1'b0, i_ptr} + (ID_W+1)'(gi);
            assign w_idx[gi]      = (w_sum >= (ID_W+1)'(N_REQ)) ?
                                    ID_W'(w_sum - (ID_W+1)'(N_REQ)) : w_sum[ID_W-1:0];
            assign w_rot_req[gi]  = i_req[w_idx[gi]];
        end
    endgenerate

    always_comb begin
        o_valid = 1'b0;
        o_id    = '0;
        o_grant = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (i_en && w_rot_req[i]) begin
                o_valid = 1'b1;
                o_id    = w_idx[i];
            end
        end
        if (o_valid) begin
            o_grant[o_id] = 1'b1;
        end
    end

endmodule

// File: rtl/cordic_request_arbiter.sv
// Shares one pipelined CORDIC core between N_REQ requesters; a tag line matched
// to the core latency steers each result back to the requester that issued it.
module cordic_request_arbiter
    import cordic_pkg::*;
#(
    parameter int N_REQ           = 4,
    parameter int INTEGER_BITS    = CORDIC_INT_BITS,
    parameter int FRACTIONAL_BITS = CORDIC_FRAC_BITS,
    parameter int BITS            = INTEGER_BITS + FRACTIONAL_BITS,
    parameter int CORE_LATENCY    = CORDIC_LATENCY,
    parameter int ID_W            = $clog2(N_REQ)
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic                        i_stall,
    input  logic [N_REQ-1:0]            i_req_valid,
    output logic [N_REQ-1:0]            o_req_ready,
    input  logic [N_REQ-1:0][BITS-1:0]  i_req_x,
    input  logic [N_REQ-1:0][BITS-1:0]  i_req_y,
    input  logic [N_REQ-1:0][BITS-1:0]  i_req_z,
    input  logic [N_REQ-1:0][1:0]       i_req_mode,
    input  logic [N_REQ-1:0]            i_req_rot_en,
    output logic                        o_c_ready,
    output logic [BITS-1:0]             o_c_x,
    output logic [BITS-1:0]             o_c_y,
    output logic [BITS-1:0]             o_c_z,
    output logic [1:0]                  o_c_mode,
    output logic                        o_c_rot_en,
    input  logic                        i_c_valid,
    input  logic [BITS-1:0]             i_c_x,
    input  logic [BITS-1:0]             i_c_y,
    input  logic [BITS-1:0]             i_c_z,
    output logic                        o_rsp_valid,
    output logic [ID_W-1:0]             o_rsp_id,
    output logic [BITS-1:0]             o_rsp_x,
    output logic [BITS-1:0]             o_rsp_y,
    output logic [BITS-1:0]             o_rsp_z,
    output logic                        o_busy,
    output logic                        o_err
);

    localparam int CNT_W = $clog2(CORE_LATENCY + 2);

    logic                        w_en;
    logic                        w_accept;
    logic                        w_retire;
    logic [N_REQ-1:0]            w_grant;
    logic [ID_W-1:0]             w_grant_id;

    logic [ID_W-1:0]                     r_ptr;
    logic                                r_c_ready;
    logic [BITS-1:0]                     r_c_x;
    logic [BITS-1:0]                     r_c_y;
    logic [BITS-1:0]                     r_c_z;
    logic [1:0]                          r_c_mode;
    logic                                r_c_rot_en;
    logic [ID_W-1:0]                     r_issue_id;
    logic [CORE_LATENCY-1:0]             r_tag_valid;
    logic [CORE_LATENCY-1:0][ID_W-1:0]   r_tag_id;
    logic [CNT_W-1:0]                    r_count;
    logic                                r_err;

    // Reset gates the grant so nothing is accepted while the core is being flushed.
    assign w_en = !i_stall && !i_rst;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_rr_arbiter (
        .i_req   (i_req_valid),
        .i_ptr   (r_ptr),
        .i_en    (w_en),
        .o_grant (w_grant),
        .o_id    (w_grant_id),
        .o_valid (w_accept)
    );

    assign o_req_ready = w_grant;
    assign w_retire    = r_tag_valid[CORE_LATENCY-1];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ptr <= '0;
        end else if (w_accept) begin
            r_ptr <= (w_grant_id == ID_W'(N_REQ - 1)) ? '0 : w_grant_id + 1'b1;
        end
    end

    // Issue register: operands hold their last value while the strobe is low.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_c_ready  <= 1'b0;
            r_c_x      <= '0;
            r_c_y      <= '0;
            r_c_z      <= '0;
            r_c_mode   <= '0;
            r_c_rot_en <= 1'b0;
            r_issue_id <= '0;
        end else begin
            r_c_ready <= w_accept;
            if (w_accept) begin
                r_c_x      <= i_req_x[w_grant_id];
                r_c_y      <= i_req_y[w_grant_id];
                r_c_z      <= i_req_z[w_grant_id];
                r_c_mode   <= i_req_mode[w_grant_id];
                r_c_rot_en <= i_req_rot_en[w_grant_id];
                r_issue_id <= w_grant_id;
            end
        end
    end

    // Tag line runs alongside the core so its last stage lines up with i_c_valid.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_tag_valid <= '0;
            r_tag_id    <= '0;
        end else begin
            r_tag_valid <= {r_tag_valid[CORE_LATENCY-2:0], r_c_ready};
            r_tag_id    <= {r_tag_id[CORE_LATENCY-2:0], (r_c_ready ? r_issue_id : ID_W'(0))};
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_count <= '0;
        end else begin
            case ({w_accept, w_retire})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_err <= 1'b0;
        end else if (i_c_valid != r_tag_valid[CORE_LATENCY-1]) begin
            r_err <= 1'b1;
        end
    end

    assign o_c_ready   = r_c_ready;
    assign o_c_x       = r_c_x;
    assign o_c_y       = r_c_y;
    assign o_c_z       = r_c_z;
    assign o_c_mode    = r_c_mode;
    assign o_c_rot_en  = r_c_rot_en;
    assign o_rsp_valid = r_tag_valid[CORE_LATENCY-1];
    assign o_rsp_id    = r_tag_id[CORE_LATENCY-1];
    assign o_rsp_x     = i_c_x;
    assign o_rsp_y     = i_c_y;
    assign o_rsp_z     = i_c_z;
    assign o_busy      = (r_count != '0);
    assign o_err       = r_err;

endmodule

// File: tb/tb_cordic_request_arbiter.sv
// Scoreboard bench for cordic_request_arbiter with a stand-in pipelined core whose
// results are a simple known transform of the issued operands.
module tb_cordic_request_arbiter;
    import cordic_pkg::*;

    localparam int N    = 4;
    localparam int BITS = CORDIC_BITS;
    localparam int CL   = CORDIC_LATENCY;
    localparam int IDW  = 2;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic                  stall = 1'b0;
    logic [N-1:0]          req_valid = '0;
    logic [N-1:0]          req_ready;
    logic [N-1:0][BITS-1:0] req_x = '0;
    logic [N-1:0][BITS-1:0] req_y = '0;
    logic [N-1:0][BITS-1:0] req_z = '0;
    logic [N-1:0][1:0]     req_mode = '0;
    logic [N-1:0]          req_rot_en = '0;
    logic                  c_ready;
    logic [BITS-1:0]       c_x, c_y, c_z;
    logic [1:0]            c_mode;
    logic                  c_rot_en;
    logic                  c_valid;
    logic [BITS-1:0]       c_rx, c_ry, c_rz;
    logic                  rsp_valid;
    logic [IDW-1:0]        rsp_id;
    logic [BITS-1:0]       rsp_x, rsp_y, rsp_z;
    logic                  busy, err;

    always #5 clk = ~clk;

    cordic_request_arbiter #(.N_REQ(N)) dut (
        .i_clk(clk), .i_rst(rst), .i_stall(stall),
        .i_req_valid(req_valid), .o_req_ready(req_ready),
        .i_req_x(req_x), .i_req_y(req_y), .i_req_z(req_z),
        .i_req_mode(req_mode), .i_req_rot_en(req_rot_en),
        .o_c_ready(c_ready), .o_c_x(c_x), .o_c_y(c_y), .o_c_z(c_z),
        .o_c_mode(c_mode), .o_c_rot_en(c_rot_en),
        .i_c_valid(c_valid), .i_c_x(c_rx), .i_c_y(c_ry), .i_c_z(c_rz),
        .o_rsp_valid(rsp_valid), .o_rsp_id(rsp_id),
        .o_rsp_x(rsp_x), .o_rsp_y(rsp_y), .o_rsp_z(rsp_z),
        .o_busy(busy), .o_err(err)
    );

    // Stand-in core: x passes, y is xored with {rot_en,mode}, z is incremented.
    logic [CL-1:0]            core_v;
    logic [CL-1:0][BITS-1:0]  core_x, core_y, core_z;
    logic                     force_valid = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            core_v <= '0; core_x <= '0; core_y <= '0; core_z <= '0;
        end else begin
            core_v <= {core_v[CL-2:0], c_ready};
            core_x <= {core_x[CL-2:0], c_x};
            core_y <= {core_y[CL-2:0], c_y ^ BITS'({c_rot_en, c_mode})};
            core_z <= {core_z[CL-2:0], c_z + BITS'(1)};
        end
    end
    assign c_valid = core_v[CL-1] | force_valid;
    assign c_rx    = core_x[CL-1];
    assign c_ry    = core_y[CL-1];
    assign c_rz    = core_z[CL-1];

    typedef struct {
        int              id;
        logic [BITS-1:0] x, y, z;
        int              due;
    } exp_t;
    exp_t sbq[$];

    int n_vec = 0;
    int n_bad = 0;
    int cyc = 0;
    int last_acc = 0;
    int seq = 0;
    logic gen_ops = 1'b1;
    logic [1:0] mode_tab [N] = '{CIRCULAR, LINEAR, HYPERBOLIC, CIRCULAR};

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Issue side: every accepted request pushes its expected response.
    always @(negedge clk) begin
        if (!rst) begin
            for (int k = 0; k < N; k++) begin
                if (req_valid[k] && req_ready[k]) begin
                    exp_t e;
                    e.id  = k;
                    e.x   = req_x[k];
                    e.y   = req_y[k] ^ BITS'({req_rot_en[k], req_mode[k]});
                    e.z   = req_z[k] + BITS'(1);
                    e.due = cyc + 1 + CL;
                    sbq.push_back(e);
                    last_acc = cyc;
                    $display("issue   cycle %0d req %0d x=%0h", cyc, k, req_x[k]);
                end
            end
        end
    end

    // Response side: pop and compare whenever the DUT presents a result.
    always @(negedge clk) begin
        if (rsp_valid === 1'b1) begin
            if (sbq.size() == 0) begin
                n_vec++; n_bad++;
                $display("FAIL rsp_unexpected: got id %0d expected no response (cycle %0d)", rsp_id, cyc);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                $display("respond cycle %0d id %0d x=%0h", cyc, rsp_id, rsp_x);
                check("rsp_id", 64'(rsp_id), 64'(e.id));
                check("rsp_x", 64'(rsp_x), 64'(e.x));
                check("rsp_y", 64'(rsp_y), 64'(e.y));
                check("rsp_z", 64'(rsp_z), 64'(e.z));
                check("rsp_cycle", 64'(cyc), 64'(e.due));
            end
        end else if (sbq.size() > 0 && sbq[0].due < cyc) begin
            n_vec++; n_bad++;
            $display("FAIL rsp_missing: got nothing expected id %0d at cycle %0d", sbq[0].id, sbq[0].due);
            void'(sbq.pop_front());
        end
        if (rst) sbq.delete();
    end

    task automatic set_ops();
        for (int k = 0; k < N; k++) begin
            req_x[k]      = to_fixed(k) + BITS'(seq);
            req_y[k]      = BITS'(seq * 3 + k);
            req_z[k]      = BITS'(seq * 5) - to_fixed(1);
            req_mode[k]   = mode_tab[k];
            req_rot_en[k] = k[0];
        end
        seq++;
    endtask

    task automatic step(input logic [N-1:0] valid, input logic stl,
                        input logic [N-1:0] exp_ready, input string nm);
        @(posedge clk); #1;
        req_valid = valid;
        stall     = stl;
        if (gen_ops) set_ops();
        @(negedge clk);
        check(nm, 64'(req_ready), 64'(exp_ready));
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1; req_valid = '0; stall = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_c_ready", 64'(c_ready), 64'd0);
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        check("rst_rsp_id", 64'(rsp_id), 64'd0);
        check("rst_c_x", 64'(c_x), 64'd0);
    endtask

    task automatic wait_idle(input string nm);
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (!busy) break;
        end
        check({nm, "_busy_low_cycle"}, 64'(cyc), 64'(last_acc + CL + 2));
        check({nm, "_err"}, 64'(err), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("init_busy", 64'(busy), 64'd0);
        check("init_c_ready", 64'(c_ready), 64'd0);

        // 1: single circular rotation from req0 with x=K
        gen_ops = 1'b0;
        req_x[0] = 33'd652032874; req_y[0] = '0; req_z[0] = '0;
        req_mode[0] = CIRCULAR; req_rot_en[0] = 1'b1;
        step(4'b0001, 1'b0, 4'b0001, "t1_grant");
        step(4'b0000, 1'b0, 4'b0000, "t1_idle");
        check("t1_c_ready", 64'(c_ready), 64'd1);
        check("t1_c_x", 64'(c_x), 64'd652032874);
        check("t1_c_mode", 64'(c_mode), 64'(CIRCULAR));
        check("t1_c_rot_en", 64'(c_rot_en), 64'd1);
        gen_ops = 1'b1;
        wait_idle("t1");

        // 2: all requesters valid for 8 cycles
        do_reset();
        for (int i = 0; i < 8; i++) step(4'b1111, 1'b0, 4'(1 << (i % 4)), "t2_grant");
        step(4'b0000, 1'b0, 4'b0000, "t2_idle");
        wait_idle("t2");

        // 3: only req1 and req3, pointer moved to 2 first
        do_reset();
        step(4'b0010, 1'b0, 4'b0010, "t3_prime");
        step(4'b1010, 1'b0, 4'b1000, "t3_grant_a");
        step(4'b1010, 1'b0, 4'b0010, "t3_grant_b");
        step(4'b1010, 1'b0, 4'b1000, "t3_grant_c");
        step(4'b0000, 1'b0, 4'b0000, "t3_idle");
        wait_idle("t3");

        // 4: continuous stream with stall on cycles 5..7
        do_reset();
        begin
            int g = 0;
            for (int i = 0; i < 22; i++) begin
                if (i >= 5 && i <= 7) begin
                    step(4'b1111, 1'b1, 4'b0000, "t4_stall");
                end else begin
                    step(4'b1111, 1'b0, 4'(1 << (g % 4)), "t4_grant");
                    g++;
                end
            end
        end
        check("t4_busy_full", 64'(busy), 64'd1);
        step(4'b0000, 1'b0, 4'b0000, "t4_idle");
        wait_idle("t4");

        // 5: reset while 10 ops are in flight, then one fresh op
        do_reset();
        for (int i = 0; i < 10; i++) step(4'b1111, 1'b0, 4'(1 << (i % 4)), "t5_grant");
        do_reset();
        repeat (20) @(negedge clk);
        check("t5_quiet_busy", 64'(busy), 64'd0);
        step(4'b0100, 1'b0, 4'b0100, "t5_new_grant");
        step(4'b0000, 1'b0, 4'b0000, "t5_idle");
        wait_idle("t5");

        // 6: spurious core valid raises a sticky error
        @(posedge clk); #1 force_valid = 1'b1;
        @(posedge clk); #1 force_valid = 1'b0;
        @(negedge clk);
        check("t6_err_set", 64'(err), 64'd1);
        repeat (5) @(negedge clk);
        check("t6_err_held", 64'(err), 64'd1);
        do_reset();

        check("sb_drain", 64'(sbq.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
